// File: rtl/maj_route_pkg.sv
// Shared types for the majority/route pipeline: mode encoding,
// stage payload and the 3-input bitwise majority helper.
package maj_route_pkg;

  // Payload is sized for the widest legal build; narrower builds
  // leave the upper bits at zero and synthesis trims them.
  localparam int MAX_W  = 64;
  localparam int MAX_IW = 4;

  typedef enum logic [1:0] {
    MODE_PRI  = 2'd0,
    MODE_IDX  = 2'd1,
    MODE_MAJ3 = 2'd2,
    MODE_MAJN = 2'd3
  } mode_e;

  typedef struct packed {
    logic [MAX_W-1:0]  data;
    logic              hit;
    logic [MAX_IW-1:0] idx;
  } payload_t;

  function automatic logic [MAX_W-1:0] maj3(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maj_route_if.sv
// Beat interface: input beat (valid/ready + mode/select/data) and
// output beat (valid/ready + data/hit/idx) plus the hit counter.
interface maj_route_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16
);
  localparam int IW = $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                mode;
  logic [IW-1:0]             sel_idx;
  logic [CHANNELS-1:0]       ch_en;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [1:0]                inhibit;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_hit;
  logic [IW-1:0]             out_idx;
  logic [CNT_W-1:0]          hit_cnt;

  modport master (
    output in_valid, mode, sel_idx, ch_en,
    output ch_data, inhibit, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_hit, out_idx, hit_cnt
  );

  modport slave (
    input  in_valid, mode, sel_idx, ch_en,
    input  ch_data, inhibit, out_ready,
    output in_ready, out_valid, out_data,
    output out_hit, out_idx, hit_cnt
  );
endinterface

// File: rtl/maj_route_core.sv
// Combinational mode decode: priority / indexed / maj3 / majN select
// with inhibit masking; emits one stage payload.
module maj_route_core
  import maj_route_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic [1:0]                 mode,
  input  logic [$clog2(CHANNELS)-1:0] sel_idx,
  input  logic [CHANNELS-1:0]        ch_en,
  input  logic [CHANNELS*WIDTH-1:0]  ch_data,
  input  logic [1:0]                 inhibit,
  output payload_t                   pl
);
  localparam int IW = $clog2(CHANNELS);
  localparam logic [4:0] HALF = 5'(CHANNELS / 2);

  mode_e            m;
  logic [WIDTH-1:0] w [CHANNELS];

  logic [WIDTH-1:0] pri_d, idx_d, mjn_d;
  logic [IW-1:0]    pri_i;
  logic             pri_h, idx_h;
  logic [4:0]       votes;

  logic [MAX_W-1:0] res_d;
  logic             res_h;
  logic [IW-1:0]    res_i;

  assign m = mode_e'(mode);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_w
    assign w[i] = ch_data[i*WIDTH +: WIDTH];
  end

  // Walk downward so the lowest enabled channel wins.
  always_comb begin
    pri_h = 1'b0;
    pri_i = '0;
    pri_d = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (ch_en[i]) begin
        pri_h = 1'b1;
        pri_i = IW'(i);
        pri_d = w[i];
      end
    end
  end

  // Equality scan also rejects sel_idx values past the last channel.
  always_comb begin
    idx_h = 1'b0;
    idx_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_idx == IW'(i) && ch_en[i]) begin
        idx_h = 1'b1;
        idx_d = w[i];
      end
    end
  end

  // Threshold is a strict majority of all channels, not of enabled ones.
  always_comb begin
    mjn_d = '0;
    votes = '0;
    for (int b = 0; b < WIDTH; b++) begin
      votes = '0;
      for (int i = 0; i < CHANNELS; i++)
        votes = votes + 5'(ch_en[i] & w[i][b]);
      mjn_d[b] = votes > HALF;
    end
  end

  always_comb begin
    res_d = '0;
    res_h = 1'b0;
    res_i = '0;
    unique case (1'b1)
      m == MODE_PRI: begin
        res_d = MAX_W'(pri_d);
        res_h = pri_h;
        res_i = pri_i;
      end
      m == MODE_IDX: begin
        res_d = MAX_W'(idx_d);
        res_h = idx_h;
        res_i = idx_h ? sel_idx : '0;
      end
      m == MODE_MAJ3: begin
        res_d = maj3(MAX_W'(w[0] & {WIDTH{ch_en[0]}}),
                     MAX_W'(w[1] & {WIDTH{ch_en[1]}}),
                     MAX_W'(w[2] & {WIDTH{ch_en[2]}}));
        res_h = |ch_en[2:0];
      end
      m == MODE_MAJN: begin
        res_d = MAX_W'(mjn_d);
        res_h = |ch_en;
      end
    endcase
  end

  // Inhibit clears data/hit but keeps the would-be channel index.
  always_comb begin
    pl.data = (|inhibit) ? '0 : res_d;
    pl.hit  = res_h & ~|inhibit;
    pl.idx  = MAX_IW'(res_i);
  end

endmodule

// File: rtl/maj_route_pipe.sv
// Elastic STAGES-deep valid/ready pipeline around maj_route_core,
// with a saturating count of delivered hit beats.
module maj_route_pipe
  import maj_route_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  maj_route_if.slave  io
);
  localparam int IW = $clog2(CHANNELS);

  payload_t          pl;
  payload_t          st_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [CNT_W-1:0]  hit_q;
  logic              in_rdy;
  logic              in_fire;
  logic              out_fire;
  logic              unused_hi;

  maj_route_core #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH)
  ) u_core (
    .mode    (io.mode),
    .sel_idx (io.sel_idx),
    .ch_en   (io.ch_en),
    .ch_data (io.ch_data),
    .inhibit (io.inhibit),
    .pl      (pl)
  );

  // Advance ripples back from the output; never looks at in_valid.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = v_q[STAGES-1] & io.out_ready;
    for (int k = STAGES-2; k >= 0; k--)
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
  end

  assign in_rdy   = ~v_q[0] | adv[0];
  assign in_fire  = io.in_valid & in_rdy;
  assign out_fire = adv[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      hit_q <= '0;
      for (int k = 0; k < STAGES; k++)
        st_q[k] <= '0;
    end else begin
      if (in_fire) begin
        st_q[0] <= pl;
        v_q[0]  <= 1'b1;
      end else if (adv[0]) begin
        v_q[0]  <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          st_q[k] <= st_q[k-1];
          v_q[k]  <= 1'b1;
        end else if (adv[k]) begin
          v_q[k]  <= 1'b0;
        end
      end
      if (out_fire && st_q[STAGES-1].hit && ~&hit_q)
        hit_q <= hit_q + CNT_W'(1);
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.out_valid = v_q[STAGES-1];
  assign io.out_data  = st_q[STAGES-1].data[WIDTH-1:0];
  assign io.out_hit   = st_q[STAGES-1].hit;
  assign io.out_idx   = st_q[STAGES-1].idx[IW-1:0];
  assign io.hit_cnt   = hit_q;

  assign unused_hi = ^{st_q[STAGES-1].data, st_q[STAGES-1].idx};

endmodule

// File: tb/tb_maj_route_pipe.sv
// Directed bench for maj_route_pipe: modes, inhibit, latency,
// backpressure ordering, counter saturation and async reset.
module tb_maj_route_pipe;
  logic clk;
  logic rst_n;
  logic rst2_n;

  int checks;
  int failures;

  maj_route_if #(.CHANNELS(4), .WIDTH(8), .CNT_W(16)) io ();
  maj_route_if #(.CHANNELS(4), .WIDTH(8), .CNT_W(2))  io2 ();

  maj_route_pipe #(
    .CHANNELS(4), .WIDTH(8), .STAGES(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  maj_route_pipe #(
    .CHANNELS(4), .WIDTH(8), .STAGES(2), .CNT_W(2)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .io    (io2)
  );

  always #5 clk = ~clk;

  logic [7:0]  d;
  logic        h;
  logic [1:0]  ix;
  int          lat;
  logic [15:0] cnt;

  task automatic push(
    input  logic [1:0]  md,
    input  logic [1:0]  sel,
    input  logic [3:0]  en,
    input  logic [31:0] dat,
    input  logic [1:0]  inh
  );
    io.mode      = md;
    io.sel_idx   = sel;
    io.ch_en     = en;
    io.ch_data   = dat;
    io.inhibit   = inh;
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = io.out_data;
    h  = io.out_hit;
    ix = io.out_idx;
    @(posedge clk); #1;
    cnt = io.hit_cnt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    #12;
    checks++;
    if (io.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid got=%b exp=0", io.out_valid);
    end
    checks++;
    if (io.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=1", io.in_ready);
    end
    checks++;
    if (io.out_data !== 8'h00 || io.out_hit !== 1'b0 || io.out_idx !== 2'd0) begin
      failures++;
      $display("FAIL rst_payload got=%h/%b/%0d exp=00/0/0", io.out_data, io.out_hit, io.out_idx);
    end
    checks++;
    if (io.hit_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_hit_cnt got=%0d exp=0", io.hit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_priority;
    push(2'd0, 2'd0, 4'b0110, 32'h44332211, 2'b00);
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL pri_latency got=%0d exp=2", lat);
    end
    checks++;
    if (d !== 8'h22 || ix !== 2'd1 || h !== 1'b1) begin
      failures++;
      $display("FAIL pri_sel got=%h/%0d/%b exp=22/1/1", d, ix, h);
    end
    checks++;
    if (cnt !== 16'd1) begin
      failures++;
      $display("FAIL pri_cnt got=%0d exp=1", cnt);
    end
    push(2'd0, 2'd0, 4'b0000, 32'h44332211, 2'b00);
    checks++;
    if (d !== 8'h00 || ix !== 2'd0 || h !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL pri_none got=%h/%0d/%b/%0d exp=00/0/0/1", d, ix, h, cnt);
    end
    push(2'd0, 2'd0, 4'b1000, 32'h44332211, 2'b01);
    checks++;
    if (d !== 8'h00 || ix !== 2'd3 || h !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL pri_inhibit got=%h/%0d/%b/%0d exp=00/3/0/1", d, ix, h, cnt);
    end
  endtask

  task automatic test_indexed;
    push(2'd1, 2'd3, 4'b0111, 32'h44332211, 2'b00);
    checks++;
    if (d !== 8'h00 || ix !== 2'd0 || h !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL idx_disabled got=%h/%0d/%b/%0d exp=00/0/0/1", d, ix, h, cnt);
    end
    push(2'd1, 2'd3, 4'b1111, 32'h44332211, 2'b00);
    checks++;
    if (d !== 8'h44 || ix !== 2'd3 || h !== 1'b1 || cnt !== 16'd2) begin
      failures++;
      $display("FAIL idx_sel got=%h/%0d/%b/%0d exp=44/3/1/2", d, ix, h, cnt);
    end
  endtask

  task automatic test_maj3;
    push(2'd2, 2'd0, 4'b0111, 32'h00AACCF0, 2'b00);
    checks++;
    if (d !== 8'hE8 || ix !== 2'd0 || h !== 1'b1 || cnt !== 16'd3) begin
      failures++;
      $display("FAIL maj3_all got=%h/%0d/%b/%0d exp=e8/0/1/3", d, ix, h, cnt);
    end
    push(2'd2, 2'd0, 4'b0011, 32'h00AACCF0, 2'b00);
    checks++;
    if (d !== 8'hC0 || h !== 1'b1 || cnt !== 16'd4) begin
      failures++;
      $display("FAIL maj3_two got=%h/%b/%0d exp=c0/1/4", d, h, cnt);
    end
  endtask

  task automatic test_majn;
    push(2'd3, 2'd0, 4'b1111, 32'h01030FFF, 2'b00);
    checks++;
    if (d !== 8'h03 || ix !== 2'd0 || h !== 1'b1 || cnt !== 16'd5) begin
      failures++;
      $display("FAIL majn_all got=%h/%0d/%b/%0d exp=03/0/1/5", d, ix, h, cnt);
    end
    push(2'd3, 2'd0, 4'b1111, 32'h01030FFF, 2'b10);
    checks++;
    if (d !== 8'h00 || h !== 1'b0 || cnt !== 16'd5) begin
      failures++;
      $display("FAIL majn_inhibit got=%h/%b/%0d exp=00/0/5", d, h, cnt);
    end
  endtask

  task automatic test_backpressure;
    int   k;
    int   n;
    logic drop_seen;
    logic prev_stall;
    logic [10:0] snap;
    logic [7:0]  exp_d;
    k = 0;
    n = 0;
    drop_seen = 1'b0;
    prev_stall = 1'b0;
    snap = '0;
    io.mode = 2'd0;
    io.sel_idx = 2'd0;
    io.ch_en = 4'b0001;
    io.inhibit = 2'b00;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      io.out_ready = !(cyc >= 3 && cyc <= 7);
      io.in_valid  = (k < 8);
      io.ch_data   = {24'h0, 8'hA0 + 8'(k)};
      #1;
      if (io.out_valid && io.out_ready) begin
        exp_d = 8'hA0 + 8'(n);
        checks++;
        if (io.out_data !== exp_d) begin
          failures++;
          $display("FAIL bp_order beat=%0d got=%h exp=%h", n, io.out_data, exp_d);
        end
        if (k - n == 2) begin
          checks++;
          if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_full_shift got=%b exp=1", io.in_ready);
          end
        end
        n++;
      end
      if (io.out_valid && !io.out_ready && prev_stall) begin
        checks++;
        if ({io.out_data, io.out_hit, io.out_idx} !== snap) begin
          failures++;
          $display("FAIL bp_hold got=%h exp=%h", {io.out_data, io.out_hit, io.out_idx}, snap);
        end
      end
      prev_stall = io.out_valid && !io.out_ready;
      snap = {io.out_data, io.out_hit, io.out_idx};
      if (!io.in_ready && !drop_seen) begin
        drop_seen = 1'b1;
        checks++;
        if (k - n != 2) begin
          failures++;
          $display("FAIL bp_occupancy got=%0d exp=2", k - n);
        end
      end
      if (io.in_valid && io.in_ready) k++;
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    checks++;
    if (n != 8 || k != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d/%0d exp=8/8", k, n);
    end
    checks++;
    if (!drop_seen) begin
      failures++;
      $display("FAIL bp_ready_drop got=0 exp=1");
    end
  endtask

  task automatic test_saturate;
    int k;
    int n;
    int pend;
    logic [1:0] exp_tab [5];
    exp_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    k = 0;
    n = 0;
    pend = -1;
    io2.mode = 2'd0;
    io2.sel_idx = 2'd0;
    io2.ch_en = 4'b0001;
    io2.ch_data = 32'h0000005A;
    io2.inhibit = 2'b00;
    io2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && (n < 5 || pend >= 0); cyc++) begin
      io2.in_valid = (k < 5);
      #1;
      if (pend >= 0) begin
        checks++;
        if (io2.hit_cnt !== exp_tab[pend]) begin
          failures++;
          $display("FAIL sat_cnt beat=%0d got=%0d exp=%0d", pend, io2.hit_cnt, exp_tab[pend]);
        end
        pend = -1;
      end
      if (io2.out_valid && io2.out_ready) begin
        pend = n;
        n++;
      end
      if (io2.in_valid && io2.in_ready) k++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL sat_beats got=%0d exp=5", n);
    end
  endtask

  task automatic test_async_reset;
    io2.in_valid = 1'b1;
    io2.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (io2.out_valid !== 1'b1 || io2.hit_cnt === 2'd0) begin
      failures++;
      $display("FAIL ar_pre got=%b/%0d exp=1/nonzero", io2.out_valid, io2.hit_cnt);
    end
    #2;
    rst2_n = 1'b0;
    #1;
    checks++;
    if (io2.out_valid !== 1'b0 || io2.hit_cnt !== 2'd0 || io2.out_data !== 8'h00) begin
      failures++;
      $display("FAIL ar_clear got=%b/%0d/%h exp=0/0/00", io2.out_valid, io2.hit_cnt, io2.out_data);
    end
    io2.in_valid = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (io2.out_valid !== 1'b0 || io2.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ar_after got=%b/%b exp=0/1", io2.out_valid, io2.in_ready);
    end
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.mode = 2'd0;
    io.sel_idx = 2'd0;
    io.ch_en = 4'b0000;
    io.ch_data = 32'h0;
    io.inhibit = 2'b00;
    io2.in_valid = 1'b0;
    io2.out_ready = 1'b1;
    io2.mode = 2'd0;
    io2.sel_idx = 2'd0;
    io2.ch_en = 4'b0000;
    io2.ch_data = 32'h0;
    io2.inhibit = 2'b00;
    test_reset();
    test_priority();
    test_indexed();
    test_maj3();
    test_majn();
    test_backpressure();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maj_route_pipe.md
Name: maj_route_pipe

Overview:
- Parametrised, pipelined successor to the flat majority-gate channel-select benchmark.
- Selects or majority-combines one of CHANNELS data words.
- Supports four selectable modes, applies an output inhibit, and carries results through an elastic valid/ready pipeline.
- Sits between benchmark stimulus drivers and the result checker, and is the first sequential AQFP-flavoured block in the benchmark set.

Parameters:
- CHANNELS, 4: number of input channels; legal range 3..16.
- WIDTH, 8: bits per channel word.
- STAGES, 2: pipeline register stages; legal range 1..4.
- CNT_W, 16: width of the saturating hit counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- mode  in  2  0=priority, 1=indexed, 2=maj3, 3=majN.
- sel_idx  in  $clog2(CHANNELS)  channel index used in mode 1.
- ch_en  in  CHANNELS  per-channel enable mask.
- ch_data  in  CHANNELS*WIDTH  channel words; channel i occupies bits [i*WIDTH +: WIDTH].
- inhibit  in  2  any bit set forces a zero result with out_hit=0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  result word.
- out_hit  out  1  a channel contributed to the result.
- out_idx  out  $clog2(CHANNELS)  selected channel; 0 in modes 2 and 3.
- hit_cnt  out  CNT_W  saturating count of accepted output beats with out_hit=1.

Behaviour:
- Reset: all stage valid bits are 0, out_valid=0, out_data=0, out_hit=0, out_idx=0, hit_cnt=0. in_ready=1 after reset.
- Reset asserted mid-operation discards every in-flight beat immediately. No partial output is produced.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- The result is computed combinationally from the transfer-cycle inputs and written to stage 0.
- Stage k advances when stage k+1 is empty or stage k+1 is itself advancing. The last stage advances on an output transfer.
- in_ready = !v[0] || stage-0 advance. in_ready must not depend combinationally on in_valid.
- Latency with out_ready held at 1: out_valid rises exactly STAGES cycles after the transfer edge.
- Throughput is one beat per cycle under continuous out_ready.
- Under backpressure, beats are never dropped, duplicated or reordered. out_data, out_hit and out_idx are stable while out_valid && !out_ready.
- Mode 0 (priority): lowest i with ch_en[i]=1 is selected; out_data = word i, out_hit=1. If ch_en is all zero: out_data=0, out_hit=0, out_idx=0.
- Mode 1 (indexed): if sel_idx < CHANNELS and ch_en[sel_idx]=1, word sel_idx is selected with out_hit=1. Otherwise out_data=0, out_hit=0, out_idx=0.
- Mode 2 (maj3): bitwise MAJ(d0&m0, d1&m1, d2&m2), where mi replicates ch_en[i] across WIDTH. out_hit = |ch_en[2:0].
- Mode 3 (majN): per bit, output is 1 iff the count of enabled channels with that bit set is > CHANNELS/2 (integer division; strict majority of CHANNELS, not of enabled channels). out_hit = |ch_en.
- inhibit != 0 at transfer forces out_data=0 and out_hit=0. out_idx still reports the channel the mode would have selected.
- hit_cnt increments by 1 on each output transfer with out_hit=1. It saturates at all-ones with no wrap.
- Simultaneous input and output transfer with all stages full is legal. The pipeline shifts, occupancy is unchanged, and in_ready stays 1.

Decomposition:
- Package maj_route_pkg holds:
  - mode enum: MODE_PRI=2'd0, MODE_IDX=2'd1, MODE_MAJ3=2'd2, MODE_MAJN=2'd3.
  - stage payload struct {data, hit, idx}.
  - function maj3(a,b,c).
- Sub-module maj_route_core: purely combinational mode/select/majority/inhibit logic producing the payload.
- The top level holds the elastic stage registers and hit_cnt.

Test Plan:
- Reset then mode 0, ch_en=4'b0110, words {0x44,0x33,0x22,0x11} for ch3..ch0, out_ready=1 → after 2 cycles out_data=0x22, out_idx=1, out_hit=1, hit_cnt=1.
- Mode 1, sel_idx=3, ch_en=4'b0111 → out_data=0x00, out_hit=0, hit_cnt unchanged. Then ch_en=4'b1111 → out_data=0x44, out_idx=3.
- Mode 2, ch0=0xF0, ch1=0xCC, ch2=0xAA, ch_en=4'b0111 → out_data=0xE8. Then ch_en=4'b0011 → out_data=0xC0.
- Mode 3, CHANNELS=4, ch0..ch3={0xFF,0x0F,0x03,0x01}, all enabled → out_data=0x03 (needs ≥3 votes). With inhibit=2'b10 → out_data=0x00, out_hit=0.
- Stream 8 beats with out_ready=0 for cycles 3-7 → in_ready drops once STAGES beats are buffered, output order matches input order, held output is stable, no beat is lost.
- CNT_W=2: stream 5 hit beats → hit_cnt reads 1,2,3,3,3. Assert rst_n=0 mid-stream → out_valid=0 and hit_cnt=0 asynchronously.
